// File: rtl/ppu_quant.sv
// Post-processing quantizer behind the matmul controller: tracks the global |max| in a
// max pass, then rescales accumulator rows to INT8/INT4 with rounding and saturation.

module ppu_quant_lane #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int SH_W  = 5,
    parameter int T8    = 7,
    parameter int T4    = 3
) (
    input  logic [ACC_W-1:0] x_i,
    output logic [ACC_W-1:0] abs_o,
    input  logic [ACC_W-1:0] xq_i,
    input  logic [SH_W-1:0]  shift_i,
    input  logic             t4_i,
    output logic [OUT_W-1:0] y_o
);
    localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] HI8 = (ACC_W+1)'((1 << T8) - 1);
    localparam logic signed [ACC_W:0] HI4 = (ACC_W+1)'((1 << T4) - 1);
    localparam logic signed [ACC_W:0] LO8 = ~HI8;
    localparam logic signed [ACC_W:0] LO4 = ~HI4;

    logic signed [ACC_W:0] xe, bias, rnd, hi, lo, sat;

    // The most negative code has no positive twin; clamp it onto the largest magnitude.
    always_comb begin
        if (x_i == MIN_NEG)   abs_o = MAX_POS;
        else if (x_i[ACC_W-1]) abs_o = -x_i;
        else                  abs_o = x_i;
    end

    always_comb begin
        xe   = {xq_i[ACC_W-1], xq_i};
        bias = '0;
        rnd  = xe;
        if (shift_i != '0) begin
            bias = (ACC_W+1)'(1) << (shift_i - SH_W'(1));
            rnd  = (xe + bias) >>> shift_i;
        end
        hi = t4_i ? HI4 : HI8;
        lo = t4_i ? LO4 : LO8;
        if (rnd > hi)      sat = hi;
        else if (rnd < lo) sat = lo;
        else               sat = rnd;
        y_o = sat[OUT_W-1:0];
    end
endmodule

module ppu_quant #(
    parameter int VL    = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int SH_W  = 5,
    parameter int ROW_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic                  i_pass,
    input  logic [1:0]            i_mode,
    input  logic [ACC_W*VL-1:0]   i_acc_data,
    output logic                  o_valid,
    output logic [OUT_W*VL-1:0]   o_data,
    output logic [SH_W-1:0]       o_shift,
    output logic [ROW_W-1:0]      o_row,
    output logic                  o_tile_done,
    output logic                  o_busy,
    output logic                  o_overrun
);
    localparam logic [1:0] MODE_INT4 = 2'd1;
    localparam logic [1:0] MODE_VSQ  = 2'd2;
    localparam int T8 = 7;
    localparam int T4 = 3;
    localparam int STAGES = 2;
    localparam logic [ROW_W-1:0] LAST = ROW_W'(VL - 1);

    typedef enum logic {IDLE, WIN} state_e;

    state_e                 state_q, state_d;
    logic [ROW_W-1:0]       cnt_q, cnt_d;
    logic                   pass_q, pass_d;
    logic [1:0]             mode_q, mode_d;
    logic                   overrun_q, overrun_d;
    logic [ACC_W-1:0]       max_q, max_d;

    logic                   in_win, is_vsq, t4, calc_beat, max_beat;
    logic [ACC_W-1:0]       lane_max, ref_m;
    logic [SH_W-1:0]        bl, tlim, shift;
    logic [VL-1:0][ACC_W-1:0] abs_v;
    logic [VL-1:0][OUT_W-1:0] y_v;

    logic [STAGES:1]          vld_pipe_q;
    logic [VL-1:0][ACC_W-1:0] x1_q;
    logic [SH_W-1:0]          sh1_q, shift_q;
    logic [ROW_W-1:0]         row1_q, row_q;
    logic                     t4_1_q, last1_q, done_q;
    logic [VL-1:0][OUT_W-1:0] data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        mode_d    = mode_q;
        overrun_d = 1'b0;
        if (i_start) begin
            state_d   = WIN;
            cnt_d     = '0;
            pass_d    = i_pass;
            mode_d    = i_mode;
            overrun_d = (state_q == WIN) && (cnt_q != LAST);
        end else if (state_q == WIN) begin
            if (cnt_q == LAST) state_d = IDLE;
            else               cnt_d   = cnt_q + ROW_W'(1);
        end
    end

    assign in_win    = (state_q == WIN);
    assign is_vsq    = (mode_q == MODE_VSQ);
    assign t4        = (mode_q == MODE_INT4) || is_vsq;
    assign calc_beat = in_win && (pass_q || is_vsq);
    assign max_beat  = in_win && !pass_q && !is_vsq;

    for (genvar g = 0; g < VL; g++) begin : g_lane
        ppu_quant_lane #(
            .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W), .T8(T8), .T4(T4)
        ) u_lane (
            .x_i     (i_acc_data[g*ACC_W +: ACC_W]),
            .abs_o   (abs_v[g]),
            .xq_i    (x1_q[g]),
            .shift_i (sh1_q),
            .t4_i    (t4_1_q),
            .y_o     (y_v[g])
        );
    end

    always_comb begin
        lane_max = '0;
        for (int g = 0; g < VL; g++)
            if (abs_v[g] > lane_max) lane_max = abs_v[g];
    end

    // Per-row scaling in VSQ follows the live beat; the other modes share the matrix max.
    always_comb begin
        ref_m = is_vsq ? lane_max : max_q;
        bl    = '0;
        for (int i = 0; i < ACC_W; i++)
            if (ref_m[i]) bl = SH_W'(i + 1);
        tlim  = t4 ? SH_W'(T4) : SH_W'(T8);
        shift = (bl > tlim) ? (bl - tlim) : '0;
    end

    always_comb begin
        max_d = max_q;
        if (i_clear)                            max_d = max_beat ? lane_max : '0;
        else if (max_beat && lane_max > max_q)  max_d = lane_max;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pass_q     <= 1'b0;
            mode_q     <= '0;
            overrun_q  <= 1'b0;
            max_q      <= '0;
            vld_pipe_q <= '0;
            x1_q       <= '0;
            sh1_q      <= '0;
            row1_q     <= '0;
            t4_1_q     <= 1'b0;
            last1_q    <= 1'b0;
            data_q     <= '0;
            shift_q    <= '0;
            row_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            mode_q     <= mode_d;
            overrun_q  <= overrun_d;
            max_q      <= max_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], calc_beat};
            if (calc_beat) begin
                x1_q    <= i_acc_data;
                sh1_q   <= shift;
                row1_q  <= cnt_q;
                t4_1_q  <= t4;
                last1_q <= (cnt_q == LAST);
            end
            if (vld_pipe_q[1]) begin
                data_q  <= y_v;
                shift_q <= sh1_q;
                row_q   <= row1_q;
            end
            done_q <= vld_pipe_q[1] & last1_q;
        end
    end

    assign o_valid     = vld_pipe_q[STAGES];
    assign o_data      = data_q;
    assign o_shift     = shift_q;
    assign o_row       = row_q;
    assign o_tile_done = done_q;
    assign o_busy      = in_win | (|vld_pipe_q);
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_ppu_quant.sv
// Directed bench for ppu_quant: max/calc passes, VSQ rows, boundary codes, restarts, reset.
module tb_ppu_quant;
    localparam int VL = 8, ACC_W = 24, OUT_W = 8, SH_W = 5, ROW_W = 3;
    localparam logic [1:0] M_INT8 = 2'd0, M_INT4 = 2'd1, M_VSQ = 2'd2;

    logic                i_clk = 1'b0, i_rst_n = 1'b0, i_clear = 1'b0;
    logic                i_start = 1'b0, i_pass = 1'b0;
    logic [1:0]          i_mode = '0;
    logic [ACC_W*VL-1:0] i_acc_data = '0;
    logic                o_valid, o_tile_done, o_busy, o_overrun;
    logic [OUT_W*VL-1:0] o_data;
    logic [SH_W-1:0]     o_shift;
    logic [ROW_W-1:0]    o_row;

    int n_cmp = 0, n_err = 0;
    logic [SH_W+ROW_W+1:0] got, exp;

    always #5 i_clk = ~i_clk;

    ppu_quant #(.VL(VL), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W), .ROW_W(ROW_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_start(i_start),
        .i_pass(i_pass), .i_mode(i_mode), .i_acc_data(i_acc_data),
        .o_valid(o_valid), .o_data(o_data), .o_shift(o_shift), .o_row(o_row),
        .o_tile_done(o_tile_done), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_lane(input int g, input int v);
        i_acc_data[g*ACC_W +: ACC_W] = ACC_W'(v);
    endtask

    function automatic int lane(input int g);
        logic [OUT_W-1:0] b;
        b = o_data[g*OUT_W +: OUT_W];
        return int'($signed(b));
    endfunction

    task automatic start(input logic pass, input logic [1:0] mode);
        i_start = 1'b1; i_pass = pass; i_mode = mode;
        tick;
        i_start = 1'b0;
        n_cmp++;
        if (o_overrun !== 1'b0) begin n_err++; $display("FAIL idle_start_overrun got %0b exp 0", o_overrun); end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({o_valid, o_data, o_shift, o_row, o_tile_done, o_busy, o_overrun} !== '0) begin
            n_err++; $display("FAIL reset_outputs got v=%0b d=%h s=%0d r=%0d td=%0b b=%0b ov=%0b exp all 0",
                              o_valid, o_data, o_shift, o_row, o_tile_done, o_busy, o_overrun);
        end
    endtask

    task automatic test_int8;
        i_clear = 1'b1; tick; i_clear = 1'b0;
        start(1'b0, M_INT8);
        for (int t = 0; t < 8; t++) begin
            i_acc_data = '0;
            if (t == 2) begin set_lane(3, 1000); set_lane(0, -300); set_lane(5, 999); end
            else begin set_lane(1, -50 * t); set_lane(6, 200 + t); end
            tick;
            n_cmp++;
            if ({o_valid, o_tile_done, o_busy} !== {1'b0, 1'b0, t < 7}) begin
                n_err++; $display("FAIL maxpass t=%0d got v/td/busy=%b exp %b", t, {o_valid, o_tile_done, o_busy}, {2'b00, t < 7});
            end
        end
        i_acc_data = '0;
        start(1'b1, M_INT8);
        for (int t = 0; t < 9; t++) begin
            i_acc_data = '0;
            if (t == 0) begin set_lane(0, 1000); set_lane(1, -1000); set_lane(2, 1020); end
            else if (t < 8) begin set_lane(0, 8 * t); set_lane(7, -8 * t); end
            tick;
            if (t == 0) begin
                n_cmp++;
                if (o_valid !== 1'b0) begin n_err++; $display("FAIL int8_c1_valid got %0b exp 0", o_valid); end
            end else begin
                int b = t - 1;
                got = {o_valid, o_shift, o_row, o_tile_done};
                exp = {1'b1, SH_W'(3), ROW_W'(b), b == 7};
                n_cmp++;
                if (got !== exp) begin n_err++; $display("FAIL int8_row b=%0d got %h exp %h", b, got, exp); end
                n_cmp++;
                if (b == 0) begin
                    if (lane(0) !== 125 || lane(1) !== -125 || lane(2) !== 127) begin
                        n_err++; $display("FAIL int8_lanes got %0d %0d %0d exp 125 -125 127", lane(0), lane(1), lane(2));
                    end
                end else if (lane(0) !== b || lane(7) !== -b) begin
                    n_err++; $display("FAIL int8_lane b=%0d got %0d %0d exp %0d %0d", b, lane(0), lane(7), b, -b);
                end
            end
        end
        tick;
        n_cmp++;
        if ({o_valid, o_busy} !== 2'b00) begin n_err++; $display("FAIL int8_drain got v/busy=%b exp 00", {o_valid, o_busy}); end
    endtask

    task automatic test_minval;
        i_clear = 1'b1; tick; i_clear = 1'b0;
        start(1'b0, M_INT8);
        for (int t = 0; t < 8; t++) begin
            i_acc_data = '0;
            if (t == 4) set_lane(2, -8388608);
            tick;
        end
        start(1'b1, M_INT8);
        for (int t = 0; t < 9; t++) begin
            i_acc_data = '0;
            if (t == 0) begin set_lane(0, -8388608); set_lane(1, 8388607); set_lane(2, 327680); end
            tick;
            if (t == 1) begin
                got = {o_valid, o_shift, o_row, o_tile_done};
                exp = {1'b1, SH_W'(16), ROW_W'(0), 1'b0};
                n_cmp++;
                if (got !== exp) begin n_err++; $display("FAIL minval_row got %h exp %h (shift 16)", got, exp); end
                n_cmp++;
                if (lane(0) !== -128 || lane(1) !== 127 || lane(2) !== 5) begin
                    n_err++; $display("FAIL minval_lanes got %0d %0d %0d exp -128 127 5", lane(0), lane(1), lane(2));
                end
            end
        end
        tick;
    endtask

    task automatic test_clear_beat;
        start(1'b0, M_INT8);
        for (int t = 0; t < 8; t++) begin
            i_acc_data = '0;
            i_clear = (t == 0);
            if (t == 0) set_lane(4, 1000);
            tick;
        end
        i_clear = 1'b0;
        start(1'b1, M_INT8);
        for (int t = 0; t < 9; t++) begin
            i_acc_data = '0;
            if (t == 0) set_lane(0, 1000);
            tick;
            if (t == 1) begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_shift !== SH_W'(3) || lane(0) !== 125) begin
                    n_err++; $display("FAIL clear_beat got v=%0b s=%0d l0=%0d exp v=1 s=3 l0=125", o_valid, o_shift, lane(0));
                end
            end
        end
        tick;
    endtask

    task automatic test_vsq;
        start(1'b0, M_VSQ);
        for (int t = 0; t < 9; t++) begin
            i_acc_data = '0;
            if (t == 0) begin set_lane(0, 100); set_lane(1, -37); end
            if (t == 2) begin set_lane(0, 7); set_lane(1, -8); end
            tick;
            if (t > 0) begin
                int b = t - 1;
                int s = (b == 0) ? 4 : (b == 2) ? 1 : 0;
                got = {o_valid, o_shift, o_row, o_tile_done};
                exp = {1'b1, SH_W'(s), ROW_W'(b), b == 7};
                n_cmp++;
                if (got !== exp) begin n_err++; $display("FAIL vsq_row b=%0d got %h exp %h", b, got, exp); end
                n_cmp++;
                if (b == 0 && (lane(0) !== 6 || lane(1) !== -2 || lane(2) !== 0)) begin
                    n_err++; $display("FAIL vsq_lanes0 got %0d %0d %0d exp 6 -2 0", lane(0), lane(1), lane(2));
                end else if (b == 2 && (lane(0) !== 4 || lane(1) !== -4)) begin
                    n_err++; $display("FAIL vsq_lanes2 got %0d %0d exp 4 -4", lane(0), lane(1));
                end else if (b != 0 && b != 2 && o_data !== '0) begin
                    n_err++; $display("FAIL vsq_zero b=%0d got %h exp 0", b, o_data);
                end
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        start(1'b1, M_INT8);
        for (int t = 0; t < 18; t++) begin
            i_acc_data = '0;
            if (t < 8) set_lane(0, 8 * t);
            else if (t < 16) set_lane(0, 128 * (t - 8));
            if (t == 0) set_lane(2, 5000);
            i_start = (t == 7); i_pass = 1'b1; i_mode = M_INT4;
            tick;
            i_start = 1'b0;
            n_cmp++;
            if (o_overrun !== 1'b0 || o_busy !== (t < 17)) begin
                n_err++; $display("FAIL b2b_ctl t=%0d got ov=%0b busy=%0b exp ov=0 busy=%0b", t, o_overrun, o_busy, t < 17);
            end
            if (t >= 1 && t <= 16) begin
                int b = t - 1;
                int r = b % 8;
                got = {o_valid, o_shift, o_row, o_tile_done};
                exp = {1'b1, SH_W'(b < 8 ? 3 : 7), ROW_W'(r), r == 7};
                n_cmp++;
                if (got !== exp || lane(0) !== r) begin
                    n_err++; $display("FAIL b2b_row b=%0d got %h l0=%0d exp %h l0=%0d", b, got, lane(0), exp, r);
                end
            end else if (t == 17) begin
                n_cmp++;
                if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail got v=%0b exp 0", o_valid); end
            end
        end
    endtask

    task automatic test_overrun;
        start(1'b1, M_INT8);
        for (int t = 0; t < 14; t++) begin
            i_acc_data = '0;
            if (t <= 3) set_lane(0, 8 * t);
            else if (t <= 11) set_lane(0, 8 * (t - 2));
            i_start = (t == 3); i_pass = 1'b1; i_mode = M_INT8;
            tick;
            i_start = 1'b0;
            n_cmp++;
            if (o_overrun !== (t == 3)) begin n_err++; $display("FAIL overrun t=%0d got %0b exp %0b", t, o_overrun, t == 3); end
            if (t >= 1 && t <= 12) begin
                int b = t - 1;
                int r = (b < 4) ? b : b - 4;
                int l = (b < 4) ? b : b - 2;
                got = {o_valid, o_shift, o_row, o_tile_done};
                exp = {1'b1, SH_W'(3), ROW_W'(r), b == 11};
                n_cmp++;
                if (got !== exp || lane(0) !== l) begin
                    n_err++; $display("FAIL overrun_row b=%0d got %h l0=%0d exp %h l0=%0d", b, got, lane(0), exp, l);
                end
            end else if (t == 13) begin
                n_cmp++;
                if ({o_valid, o_busy} !== 2'b00) begin n_err++; $display("FAIL overrun_drain got %b exp 00", {o_valid, o_busy}); end
            end
        end
    endtask

    task automatic test_reset_midflight;
        start(1'b1, M_INT8);
        i_acc_data = '0; set_lane(0, 40);
        tick;
        set_lane(0, 48);
        i_rst_n = 1'b0;
        #2;
        test_reset;
        tick; tick;
        i_rst_n = 1'b1;
        i_acc_data = '0;
        for (int t = 0; t < 4; t++) begin
            tick;
            n_cmp++;
            if ({o_valid, o_busy} !== 2'b00) begin n_err++; $display("FAIL post_reset t=%0d got v/busy=%b exp 00", t, {o_valid, o_busy}); end
        end
        start(1'b1, M_INT8);
        for (int t = 0; t < 9; t++) begin
            i_acc_data = '0;
            if (t == 0) begin set_lane(0, 5); set_lane(1, 300); end
            tick;
            if (t == 1) begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_shift !== '0 || lane(0) !== 5 || lane(1) !== 127) begin
                    n_err++; $display("FAIL max_cleared got v=%0b s=%0d l=%0d %0d exp v=1 s=0 l=5 127", o_valid, o_shift, lane(0), lane(1));
                end
            end
        end
        tick;
    endtask

    initial begin
        tick; tick;
        test_reset;
        i_rst_n = 1'b1;
        tick;
        test_int8;
        test_minval;
        test_clear_beat;
        test_vsq;
        test_back_to_back;
        test_overrun;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
